sram_like_slave: RTL



---
 rtl/sram_like_if.sv | 24 ++
 rtl/sram_like_slave.sv | 112 +++++++++++
 2 files changed

// File: rtl/sram_like_if.sv
// SRAM-like req/addr_ok/data_ok bus between a CPU port (master) and a memory (slave).
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok_mask;
  logic        addr_ok;
  logic [31:0] addr_ok_addr;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata, addr_ok_mask,
    input  addr_ok, addr_ok_addr, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata, addr_ok_mask,
    output addr_ok, addr_ok_addr, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_slave.sv
// Word-addressed memory responding on the SRAM-like bus: in-order responses after a
// fixed latency, bounded outstanding transactions, and externally injectable stalls.
module sram_like_slave #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned DATA_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  sram_like_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned LAT_W = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;

  typedef struct packed {
    logic [31:0]      rd_data;
    logic [LAT_W-1:0] cnt;
  } rsp_t;

  logic [31:0]      mem [DEPTH];
  rsp_t             q [OUTSTANDING];
  logic [OUTSTANDING-1:0] q_vld;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             addr_ok_c;
  logic             accept;
  logic             pop;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]      mem_rd;
  rsp_t             head;

  // Low address bits, upper alias bits and size do not affect behaviour.
  logic unused_bits;
  assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:ADDR_W+2]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign word_idx = bus.addr[ADDR_W+1:2];
  assign mem_rd   = mem[word_idx];
  assign head     = q[rd_ptr];

  // Acceptance: slot availability uses the current count, so a same-cycle pop never frees a slot.
  always_comb begin
    addr_ok_c = 1'b0;
    if (!reset && bus.req && !bus.addr_ok_mask && (count < CNT_W'(OUTSTANDING))) begin
      addr_ok_c = 1'b1;
    end
  end

  assign accept = bus.req & addr_ok_c;
  assign pop    = q_vld[rd_ptr] & (head.cnt == '0);

  assign bus.addr_ok      = addr_ok_c;
  assign bus.addr_ok_addr = addr_ok_c ? bus.addr : 32'h0;
  assign bus.data_ok      = pop;
  assign bus.rdata        = pop ? head.rd_data : 32'h0;

  // Byte-enabled write at the accepting edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Response queue: pointers, occupancy and per-entry latency countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      q_vld  <= '0;
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        if (accept && (wr_ptr == PTR_W'(i))) begin
          q_vld[i]     <= 1'b1;
          q[i].rd_data <= bus.wr ? 32'h0 : mem_rd;
          q[i].cnt     <= LAT_W'(DATA_LAT - 1);
        end else if (pop && (rd_ptr == PTR_W'(i))) begin
          q_vld[i] <= 1'b0;
        end else if (q_vld[i] && (q[i].cnt != '0)) begin
          q[i].cnt <= q[i].cnt - LAT_W'(1);
        end
      end
    end
  end

endmodule
